// File: rtl/rstseq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, the
// lock-loss counter geometry and the width helpers used by the top level.
package rstseq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_RESET_ALL  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_RUN        = 3'd4
    } state_e;

    // Lock-loss event counter: 8 bits, saturating.
    localparam int         LOST_CNT_W   = 8;
    localparam logic [7:0] LOST_CNT_MAX = 8'hFF;

    // Width of the shared hold/gap counter: it must reach max(hold, gap) - 1,
    // sized to max(hold, gap) + 1 so a value of exactly 1 still gets a bit.
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int longest;
        longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(longest + 1);
    endfunction

    // Width of the stage index; it holds values 0..num_out.
    function automatic int stage_width(input int num_out);
        return $clog2(num_out + 1);
    endfunction

endpackage

// File: rtl/rstseq_lock_sync.sv
// PLL lock qualification: a 2-flop synchroniser for the asynchronous lock
// input, followed by an optional consecutive-cycle filter.
// Build option: define RSTSEQ_LOCK_FILTER_EN to enable the LOCK_FILTER-cycle
// filter; without it lock_ok is the synchroniser output.
module rstseq_lock_sync #(
    parameter int LOCK_FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_locked,
    output logic lock_ok
);

`ifdef RSTSEQ_LOCK_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic [1:0] sync_q;
    logic       lock_sync;

    // Two-stage synchroniser; bit 0 may go metastable, bit 1 is the safe copy.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours; blocking here would
        // collapse the two stages into one.
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lock_sync = sync_q[1];

    // A zero-length filter degenerates to the plain synchroniser.
    if (FILTER_EN && (LOCK_FILTER > 0)) begin : g_filter
        localparam int FILT_W = $clog2(LOCK_FILTER + 1);

        logic [FILT_W-1:0] filt_cnt_q;
        logic              lock_ok_q;

        // Count consecutive synchronised-lock cycles; any 0 restarts the count
        // and drops lock_ok at once, so loss is never debounced.
        always_ff @(posedge clock) begin
            if (reset || !lock_sync) begin
                filt_cnt_q <= '0;
                lock_ok_q  <= 1'b0;
            end else if (!lock_ok_q) begin
                if (filt_cnt_q == FILT_W'(LOCK_FILTER - 1)) begin
                    lock_ok_q <= 1'b1;
                end else begin
                    filt_cnt_q <= filt_cnt_q + 1'b1;
                end
            end
        end

        assign lock_ok = lock_ok_q;
    end else begin : g_no_filter
        assign lock_ok = lock_sync;
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer. Qualifies PLL lock, holds every domain in
// reset for HOLD_CYCLES, then releases NUM_OUT resets one by one, STAGE_GAP
// cycles apart. Lock loss or a software request re-runs the sequence;
// lock-loss events are counted (saturating at 255).
// Build option: RSTSEQ_LOCK_FILTER_EN adds a LOCK_FILTER-cycle lock filter
// inside rstseq_lock_sync.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYCLES = 128,
    parameter int STAGE_GAP   = 16,
    parameter int LOCK_FILTER = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic [NUM_OUT-1:0]    rst_out,
    output logic                  ready,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int STG_W = stage_width(NUM_OUT);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(NUM_OUT - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [STG_W-1:0]        stage_q;
    logic [NUM_OUT-1:0]      rst_out_q;
    logic                    ready_q;
    logic [LOST_CNT_W-1:0]   lost_cnt_q;
    logic [LOST_CNT_W-1:0]   lost_cnt_d;
    logic                    lock_ok;
    logic                    lock_loss;

    rstseq_lock_sync #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_sync (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    // Lock loss only matters once the sequence has started counting.
    assign lock_loss = !lock_ok &&
                       ((state_q == ST_HOLD) || (state_q == ST_RELEASE) || (state_q == ST_RUN));

    // Saturating next value of the lock-loss counter.
    always_comb begin
        // NOTE: the default assignment first means every path through this
        // block drives lost_cnt_d, so no latch is inferred.
        lost_cnt_d = lost_cnt_q;
        if (lock_loss && (lost_cnt_q != LOST_CNT_MAX)) begin
            lost_cnt_d = lost_cnt_q + 1'b1;
        end
    end

    // Lock-loss event counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lost_cnt_q <= '0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    // Sequencer FSM with registered outputs; priority reset > lock loss > soft request.
    // Releases shift a zero in from bit 0, so rst_out stays a thermometer
    // code: bit `stage` is the one cleared and released bits never re-assert.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RESET_ALL;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else if (lock_loss) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            stage_q   <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET_ALL: begin
                    state_q   <= ST_WAIT_LOCK;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                end

                ST_WAIT_LOCK: begin
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                    if (lock_ok) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        stage_q <= '0;
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_out_q <= rst_out_q << 1;
                        stage_q   <= STG_W'(1);
                        cnt_q     <= '0;
                        if (NUM_OUT == 1) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        rst_out_q <= rst_out_q << 1;
                        cnt_q     <= '0;
                        if (stage_q == STG_LAST) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (soft_reset_req) begin
                        state_q   <= ST_HOLD;
                        cnt_q     <= '0;
                        stage_q   <= '0;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
                    end else begin
                        rst_out_q <= '0;
                        ready_q   <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= ST_WAIT_LOCK;
                    cnt_q     <= '0;
                    stage_q   <= '0;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out       = rst_out_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NUM_OUT=3, HOLD_CYCLES=4, STAGE_GAP=2,
// LOCK_FILTER=3) plus a NUM_OUT=1 instance. Build option RSTSEQ_LOCK_FILTER_EN
// shifts the expected latencies and enables the filter-pattern scenario.
module tb_reset_sequencer;

    localparam int NUM_OUT = 3;
    localparam int HOLD    = 4;
    localparam int GAP     = 2;
    localparam int LF      = 3;

`ifdef RSTSEQ_LOCK_FILTER_EN
    localparam int FILT_ON = 1;
`else
    localparam int FILT_ON = 0;
`endif

    // Extra edges before the first release at power-up.
    localparam int PWR_EXTRA    = FILT_ON ? LF : 0;
    // Extra edges after a 1-cycle lock drop: the filter starts refilling
    // while the loss is still propagating, so it overlaps by one edge.
    localparam int RELOCK_EXTRA = FILT_ON ? LF - 1 : 0;
    // Edges after the pll_locked drop edge before the FSM sees lock_ok=0.
    localparam int LOSS_LAT     = FILT_ON ? 3 : 2;
    // Edges from the lock-loss edge to the rst_out[0] release.
    localparam int T0           = 5 + RELOCK_EXTRA;

    logic               clock = 1'b0;
    logic               reset;
    logic               pll_locked;
    logic               soft_reset_req;
    logic [NUM_OUT-1:0] rst_out;
    logic               ready;
    logic [7:0]         lock_lost_cnt;
    logic [0:0]         rst_out1;
    logic               ready1;
    logic [7:0]         lock_lost_cnt1;

    int total = 0;
    int bad   = 0;
    int edge_n;

    reset_sequencer #(
        .NUM_OUT (NUM_OUT), .HOLD_CYCLES (HOLD), .STAGE_GAP (GAP), .LOCK_FILTER (LF)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .rst_out        (rst_out),
        .ready          (ready),
        .lock_lost_cnt  (lock_lost_cnt)
    );

    reset_sequencer #(
        .NUM_OUT (1), .HOLD_CYCLES (HOLD), .STAGE_GAP (GAP), .LOCK_FILTER (LF)
    ) dut1 (
        .clock          (clock),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .rst_out        (rst_out1),
        .ready          (ready1),
        .lock_lost_cnt  (lock_lost_cnt1)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge, then sample 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    // Expected 3-output rst_out, t edges after the HOLD entry edge offset base.
    function automatic logic [NUM_OUT-1:0] exp_rst(input int t, input int first);
        logic [NUM_OUT-1:0] v;
        for (int i = 0; i < NUM_OUT; i++) v[i] = (t < first + i * GAP);
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; pll_locked = 1'b1; soft_reset_req = 1'b0;
        repeat (3) step();
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL reset_rst: got %b want 111", rst_out); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (lock_lost_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", lock_lost_cnt); end
        total++; if (rst_out1 !== 1'b1) begin bad++; $display("FAIL reset_rst1: got %b want 1", rst_out1); end
        reset = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_power_up();
        logic [NUM_OUT-1:0] e_rst;
        for (int e = 1; e <= 14; e++) begin
            step();
            e_rst = exp_rst(e, 3 + PWR_EXTRA + HOLD);
            total++; if (rst_out !== e_rst) begin bad++; $display("FAIL pwr_rst e=%0d: got %b want %b", e, rst_out, e_rst); end
            total++; if (ready !== (e >= 11 + PWR_EXTRA)) begin bad++; $display("FAIL pwr_ready e=%0d: got %b want %b", e, ready, (e >= 11 + PWR_EXTRA)); end
            total++; if (rst_out1 !== 1'(e < 7 + PWR_EXTRA)) begin bad++; $display("FAIL pwr_rst1 e=%0d: got %b want %b", e, rst_out1, (e < 7 + PWR_EXTRA)); end
            total++; if (ready1 !== (e >= 7 + PWR_EXTRA)) begin bad++; $display("FAIL pwr_ready1 e=%0d: got %b want %b", e, ready1, (e >= 7 + PWR_EXTRA)); end
        end
    endtask

    task automatic test_lock_loss();
        int found;
        logic [NUM_OUT-1:0] e_rst;
        found = 0;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            step();
            if (rst_out === 3'b111) begin found = k; break; end
        end
        total++; if (found != LOSS_LAT + 1) begin bad++; $display("FAIL loss_latency: got %0d want %0d", found, LOSS_LAT + 1); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL loss_ready: got %b want 0", ready); end
        total++; if (lock_lost_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt: got %0d want 1", lock_lost_cnt); end
        for (int t = 1; t <= T0 + 5; t++) begin
            step();
            e_rst = exp_rst(t, T0);
            total++; if (rst_out !== e_rst) begin bad++; $display("FAIL relock_rst t=%0d: got %b want %b", t, rst_out, e_rst); end
            total++; if (ready !== (t >= T0 + 4)) begin bad++; $display("FAIL relock_ready t=%0d: got %b want %b", t, ready, (t >= T0 + 4)); end
        end
    endtask

    task automatic test_soft_reset();
        logic [NUM_OUT-1:0] e_rst;
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL soft_rst: got %b want 111", rst_out); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL soft_ready: got %b want 0", ready); end
        total++; if (lock_lost_cnt !== 8'd1) begin bad++; $display("FAIL soft_cnt: got %0d want 1", lock_lost_cnt); end
        for (int t = 1; t <= 9; t++) begin
            step();
            e_rst = exp_rst(t, 4);
            total++; if (rst_out !== e_rst) begin bad++; $display("FAIL soft_seq_rst t=%0d: got %b want %b", t, rst_out, e_rst); end
            total++; if (ready !== (t >= 8)) begin bad++; $display("FAIL soft_seq_ready t=%0d: got %b want %b", t, ready, (t >= 8)); end
        end
    endtask

    task automatic wait_ready(input string name, input int limit, input int want);
        int found;
        found = 0;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (ready === 1'b1) begin found = k; break; end
        end
        total++; if ((found == 0) || ((want != 0) && (found != want))) begin
            bad++; $display("FAIL %s: ready after %0d edges want %0d (0=any within %0d)", name, found, want, limit);
        end
    endtask

    task automatic test_soft_and_loss();
        logic [NUM_OUT-1:0] e_rst;
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        repeat (LOSS_LAT - 1) step();
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL both_rst: got %b want 111", rst_out); end
        total++; if (lock_lost_cnt !== 8'd2) begin bad++; $display("FAIL both_cnt: got %0d want 2", lock_lost_cnt); end
        for (int t = 1; t <= T0; t++) begin
            step();
            e_rst = exp_rst(t, T0);
            total++; if (rst_out !== e_rst) begin bad++; $display("FAIL both_seq t=%0d: got %b want %b", t, rst_out, e_rst); end
        end
        wait_ready("both_ready", 20, 0);
    endtask

    task automatic test_soft_in_hold();
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        step();
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        step();
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL hold_soft_t3: got %b want 111", rst_out); end
        step();
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL hold_soft_t4: got %b want 110", rst_out); end
        total++; if (lock_lost_cnt !== 8'd2) begin bad++; $display("FAIL hold_soft_cnt: got %0d want 2", lock_lost_cnt); end
        wait_ready("hold_soft_ready", 10, 4);
    endtask

    task automatic test_reset_mid_release();
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        repeat (6) step();
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL mid_pre: got %b want 100", rst_out); end
        reset = 1'b1;
        step();
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL mid_rst: got %b want 111", rst_out); end
        total++; if (lock_lost_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", lock_lost_cnt); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", ready); end
        reset = 1'b0;
        edge_n = 0;
        repeat (10 + PWR_EXTRA) step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_restart_early: got %b want 0", ready); end
        step();
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_restart_ready: got %b want 1", ready); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b1;
            repeat (8) step();
            pll_locked = 1'b0;
            repeat (6) step();
            if (i == 254) begin
                total++; if (lock_lost_cnt !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", lock_lost_cnt); end
            end
        end
        total++; if (lock_lost_cnt !== 8'd255) begin bad++; $display("FAIL sat_300: got %0d want 255", lock_lost_cnt); end
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL sat_rst: got %b want 111", rst_out); end
    endtask

`ifdef RSTSEQ_LOCK_FILTER_EN
    task automatic test_filter();
        logic pat [1:6];
        pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
        pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b1;
        reset = 1'b1; pll_locked = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        edge_n = 0;
        for (int e = 1; e <= 14; e++) begin
            pll_locked = (e <= 6) ? pat[e] : 1'b1;
            step();
            total++; if (rst_out[0] !== (e < 13)) begin bad++; $display("FAIL filt_rst0 e=%0d: got %b want %b", e, rst_out[0], (e < 13)); end
            total++; if (ready1 !== (e >= 13)) begin bad++; $display("FAIL filt_ready1 e=%0d: got %b want %b", e, ready1, (e >= 13)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_soft_reset();
        test_soft_and_loss();
        test_soft_in_hold();
        test_reset_mid_release();
        test_saturation();
`ifdef RSTSEQ_LOCK_FILTER_EN
        test_filter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
